axis_frame_arbiter: RTL and testbench

AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

---
 rtl/axis_frame_arbiter.sv | 179 +++++++++++++++++
 tb/tb_axis_frame_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter
//   Two-requester AXI4-Stream arbiter that hands the shared downstream stream
//   to one source at a time. Ownership is round robin and is released on a
//   counted TLAST. There is always exactly one idle bubble cycle between grants.
//
//   Optional feature macro: ARB_FRAME_LOCK_EN
//     undefined : per-line round robin. TUSER is ignored for eligibility, and
//                 every counted TLAST ends the grant.
//     defined   : whole-frame ownership. A source is eligible only when it
//                 presents TUSER=1. The grant ends on the counted TLAST that
//                 completes line LINES_PER_FRAME-1.
//
// Parameters
//   C_AXIS_TDATA_WIDTH : TDATA width of all streams (TSTRB is width/8)
//   LINES_PER_FRAME    : TLAST count per frame, 1..4095
//
// Ports
//   AXIS_ACLK, AXIS_ARESETN             : clock, synchronous active-low reset
//   S0_AXIS_* / S1_AXIS_*               : requester streams (TUSER = start of frame)
//   M_AXIS_*                            : shared downstream stream
//   GRANT                               : one-hot current owner, 00 = none
//   LINE_CNT                            : completed lines in the current grant
//   FRAME_DONE                          : one-cycle pulse after the grant-ending TLAST
//   SOF_ERR                             : sticky, TUSER seen on a mid-grant beat
module axis_frame_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int LINES_PER_FRAME    = 1024
) (
  input  logic                            AXIS_ACLK,
  input  logic                            AXIS_ARESETN,
  input  logic                            S0_AXIS_TVALID,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   S0_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S0_AXIS_TSTRB,
  input  logic                            S0_AXIS_TLAST,
  input  logic                            S0_AXIS_TUSER,
  output logic                            S0_AXIS_TREADY,
  input  logic                            S1_AXIS_TVALID,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   S1_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S1_AXIS_TSTRB,
  input  logic                            S1_AXIS_TLAST,
  input  logic                            S1_AXIS_TUSER,
  output logic                            S1_AXIS_TREADY,
  output logic                            M_AXIS_TVALID,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TUSER,
  input  logic                            M_AXIS_TREADY,
  output logic [1:0]                      GRANT,
  output logic [11:0]                     LINE_CNT,
  output logic                            FRAME_DONE,
  output logic                            SOF_ERR
);

  if (LINES_PER_FRAME < 1 || LINES_PER_FRAME > 4095) begin : g_lpf_range
    $error("axis_frame_arbiter: LINES_PER_FRAME must be in 1..4095");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state;
  logic        last;
  logic        first_beat;
  logic [11:0] line_cnt;
  logic        frame_done;
  logic        sof_err;

  logic        elig0;
  logic        elig1;
  logic        grant_end;
  logic        beat_fire;

`ifdef ARB_FRAME_LOCK_EN
  localparam logic [11:0] LAST_LINE = 12'(LINES_PER_FRAME - 1);

  // A frame may only be claimed at its first beat.
  assign elig0     = S0_AXIS_TVALID & S0_AXIS_TUSER;
  assign elig1     = S1_AXIS_TVALID & S1_AXIS_TUSER;
  assign grant_end = (line_cnt == LAST_LINE);
`else
  assign elig0     = S0_AXIS_TVALID;
  assign elig1     = S1_AXIS_TVALID;
  assign grant_end = 1'b1;
`endif

  // Zero-latency pass-through of the owner's stream. Everything is gated by
  // the reset input so the outputs go quiet as soon as reset is asserted,
  // even before the first clock edge.
  always_comb begin
    M_AXIS_TVALID  = 1'b0;
    M_AXIS_TDATA   = '0;
    M_AXIS_TSTRB   = '0;
    M_AXIS_TLAST   = 1'b0;
    M_AXIS_TUSER   = 1'b0;
    S0_AXIS_TREADY = 1'b0;
    S1_AXIS_TREADY = 1'b0;
    GRANT          = 2'b00;
    if (AXIS_ARESETN) begin
      case (state)
        GNT0: begin
          M_AXIS_TVALID  = S0_AXIS_TVALID;
          M_AXIS_TDATA   = S0_AXIS_TDATA;
          M_AXIS_TSTRB   = S0_AXIS_TSTRB;
          M_AXIS_TLAST   = S0_AXIS_TLAST;
          M_AXIS_TUSER   = S0_AXIS_TUSER;
          S0_AXIS_TREADY = M_AXIS_TREADY;
          GRANT          = 2'b01;
        end
        GNT1: begin
          M_AXIS_TVALID  = S1_AXIS_TVALID;
          M_AXIS_TDATA   = S1_AXIS_TDATA;
          M_AXIS_TSTRB   = S1_AXIS_TSTRB;
          M_AXIS_TLAST   = S1_AXIS_TLAST;
          M_AXIS_TUSER   = S1_AXIS_TUSER;
          S1_AXIS_TREADY = M_AXIS_TREADY;
          GRANT          = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign beat_fire = M_AXIS_TVALID & M_AXIS_TREADY;

  // Arbitration FSM. Releasing a grant always returns to IDLE for one cycle,
  // which is the bubble between owners. 'last' remembers the previous owner,
  // so a tie goes to the other requester.
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      state      <= IDLE;
      last       <= 1'b1;
      first_beat <= 1'b0;
      line_cnt   <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 && (!elig1 || last)) begin
            state      <= GNT0;
            first_beat <= 1'b1;
          end else if (elig1) begin
            state      <= GNT1;
            first_beat <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (beat_fire) begin
            first_beat <= 1'b0;
            if (M_AXIS_TUSER && !first_beat) begin
              sof_err <= 1'b1;
            end
            if (M_AXIS_TLAST) begin
              if (grant_end) begin
                state      <= IDLE;
                last       <= (state == GNT1);
                line_cnt   <= '0;
                frame_done <= 1'b1;
              end else begin
                line_cnt <= line_cnt + 12'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign LINE_CNT   = line_cnt;
  assign FRAME_DONE = frame_done;
  assign SOF_ERR    = sof_err;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb_axis_frame_arbiter
//   Scoreboard bench for axis_frame_arbiter with LINES_PER_FRAME=4. The two
//   sources are fed from per-source beat queues. Whenever a line is queued to
//   a source, its beats are also pushed to the expected-output queue in the
//   order the arbiter should emit them. Every accepted downstream beat is
//   popped and compared. A small model follows LINE_CNT, FRAME_DONE and
//   SOF_ERR cycle by cycle.
module tb_axis_frame_arbiter;

  localparam int W   = 32;
  localparam int SW  = W / 8;
  localparam int LPF = 4;
`ifdef ARB_FRAME_LOCK_EN
  localparam int GL = LPF;
`else
  localparam int GL = 1;
`endif

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] strb;
    logic          last;
    logic          user;
  } beat_t;

  typedef struct packed {
    logic [1:0] grant;
    beat_t      beat;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          S0_AXIS_TVALID, S0_AXIS_TLAST, S0_AXIS_TUSER, S0_AXIS_TREADY;
  logic [W-1:0]  S0_AXIS_TDATA;
  logic [SW-1:0] S0_AXIS_TSTRB;
  logic          S1_AXIS_TVALID, S1_AXIS_TLAST, S1_AXIS_TUSER, S1_AXIS_TREADY;
  logic [W-1:0]  S1_AXIS_TDATA;
  logic [SW-1:0] S1_AXIS_TSTRB;
  logic          M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TREADY;
  logic [W-1:0]  M_AXIS_TDATA;
  logic [SW-1:0] M_AXIS_TSTRB;
  logic [1:0]    GRANT;
  logic [11:0]   LINE_CNT;
  logic          FRAME_DONE, SOF_ERR;

  beat_t s0_q[$];
  beat_t s1_q[$];
  exp_t  exp_q[$];

  int          checks = 0;
  int          passes = 0;
  bit          ready_toggle = 1'b0;
  bit          first_after_reset = 1'b0;
  logic [11:0] exp_lc = '0;
  logic        exp_fd = 1'b0;
  logic        exp_sof = 1'b0;
  bit          exp_first = 1'b1;
  int          lines_in_grant = 0;

  axis_frame_arbiter #(
    .C_AXIS_TDATA_WIDTH(W),
    .LINES_PER_FRAME(LPF)
  ) dut (
    .AXIS_ACLK(clk),
    .AXIS_ARESETN(resetn),
    .S0_AXIS_TVALID(S0_AXIS_TVALID),
    .S0_AXIS_TDATA(S0_AXIS_TDATA),
    .S0_AXIS_TSTRB(S0_AXIS_TSTRB),
    .S0_AXIS_TLAST(S0_AXIS_TLAST),
    .S0_AXIS_TUSER(S0_AXIS_TUSER),
    .S0_AXIS_TREADY(S0_AXIS_TREADY),
    .S1_AXIS_TVALID(S1_AXIS_TVALID),
    .S1_AXIS_TDATA(S1_AXIS_TDATA),
    .S1_AXIS_TSTRB(S1_AXIS_TSTRB),
    .S1_AXIS_TLAST(S1_AXIS_TLAST),
    .S1_AXIS_TUSER(S1_AXIS_TUSER),
    .S1_AXIS_TREADY(S1_AXIS_TREADY),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TSTRB(M_AXIS_TSTRB),
    .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .GRANT(GRANT),
    .LINE_CNT(LINE_CNT),
    .FRAME_DONE(FRAME_DONE),
    .SOF_ERR(SOF_ERR)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Queue one line on a source and its expected output beats on the scoreboard.
  // TUSER marks the first beat of each frame. err_beat >= 0 adds a stray TUSER.
  task automatic makeLine(input int src, input int line, input int len,
                          input int err_beat, input bit no_sof);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < len; i++) begin
      b.data = {8'(src), 8'(line), 8'(i), 8'($urandom_range(0, 255))};
      b.strb = SW'(i + line + 1);
      b.last = (i == len - 1);
      b.user = ((i == 0) && (line % GL == 0) && !no_sof) || (i == err_beat);
      if (src == 0) s0_q.push_back(b);
      else s1_q.push_back(b);
      e.grant = (src == 0) ? 2'b01 : 2'b10;
      e.beat  = b;
      exp_q.push_back(e);
    end
  endtask

  task automatic applyStimulus();
    beat_t b;
    if (s0_q.size() > 0) begin
      b = s0_q[0];
      S0_AXIS_TVALID = 1'b1;
      {S0_AXIS_TDATA, S0_AXIS_TSTRB, S0_AXIS_TLAST, S0_AXIS_TUSER} = b;
    end else begin
      S0_AXIS_TVALID = 1'b0;
      {S0_AXIS_TDATA, S0_AXIS_TSTRB, S0_AXIS_TLAST, S0_AXIS_TUSER} = '0;
    end
    if (s1_q.size() > 0) begin
      b = s1_q[0];
      S1_AXIS_TVALID = 1'b1;
      {S1_AXIS_TDATA, S1_AXIS_TSTRB, S1_AXIS_TLAST, S1_AXIS_TUSER} = b;
    end else begin
      S1_AXIS_TVALID = 1'b0;
      {S1_AXIS_TDATA, S1_AXIS_TSTRB, S1_AXIS_TLAST, S1_AXIS_TUSER} = '0;
    end
  endtask

  task automatic resetModel();
    exp_lc         = '0;
    exp_fd         = 1'b0;
    exp_sof        = 1'b0;
    exp_first      = 1'b1;
    lines_in_grant = 0;
  endtask

  // One clock: sample and check at the falling edge, then advance sources and
  // downstream ready just after the rising edge.
  task automatic stepCycle();
    bit   f0, f1, fm, rel;
    exp_t e;
    @(negedge clk);
    f0 = S0_AXIS_TVALID && S0_AXIS_TREADY;
    f1 = S1_AXIS_TVALID && S1_AXIS_TREADY;
    fm = M_AXIS_TVALID && M_AXIS_TREADY;
    if (first_after_reset) begin
      checkOutput("post_reset_quiet",
                  {GRANT, M_AXIS_TVALID, S0_AXIS_TREADY, S1_AXIS_TREADY}, '0);
      first_after_reset = 1'b0;
    end
    checkOutput("line_cnt", LINE_CNT, exp_lc);
    checkOutput("frame_done", FRAME_DONE, exp_fd);
    checkOutput("sof_err", SOF_ERR, exp_sof);
    if (exp_fd) checkOutput("bubble", {GRANT, M_AXIS_TVALID}, '0);
    rel = 1'b0;
    if (fm) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("grant", GRANT, e.grant);
        checkOutput("beat", {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TUSER}, e.beat);
      end
      if (M_AXIS_TUSER && !exp_first) exp_sof = 1'b1;
      if (M_AXIS_TLAST) begin
        if (lines_in_grant == GL - 1) begin
          rel = 1'b1;
          lines_in_grant = 0;
          exp_lc = '0;
        end else begin
          lines_in_grant++;
          exp_lc = exp_lc + 12'd1;
        end
      end
      exp_first = rel;
    end
    exp_fd = rel;
    @(posedge clk);
    #1;
    if (f0 && s0_q.size() > 0) void'(s0_q.pop_front());
    if (f1 && s1_q.size() > 0) void'(s1_q.pop_front());
    M_AXIS_TREADY = ready_toggle ? ~M_AXIS_TREADY : 1'b1;
    applyStimulus();
  endtask

  task automatic drain(input int budget, output int cycles);
    cycles = 0;
    while (s0_q.size() > 0 || s1_q.size() > 0 || exp_q.size() > 0) begin
      if (cycles >= budget) begin
        checkOutput("drain_timeout", cycles, budget - 1);
        s0_q.delete();
        s1_q.delete();
        exp_q.delete();
        applyStimulus();
        break;
      end
      stepCycle();
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    M_AXIS_TREADY = 1'b1;

    // Scenario A is queued while reset is held, so both sources are already
    // valid during reset. The outputs must still stay quiet.
    for (int u = 0; u < 2; u++) begin
      for (int l = 0; l < GL; l++) makeLine(0, u * GL + l, 8, -1, 1'b0);
      for (int l = 0; l < GL; l++) makeLine(1, u * GL + l, 8, -1, 1'b0);
    end
    applyStimulus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_quiet", {GRANT, M_AXIS_TVALID, S0_AXIS_TREADY, S1_AXIS_TREADY}, '0);
    checkOutput("reset_status", {SOF_ERR, FRAME_DONE, LINE_CNT}, '0);
    @(posedge clk);
    #1 resetn = 1'b1;
    first_after_reset = 1'b1;
    resetModel();

    // A: both sources always valid. Owners alternate starting with S0, and
    // each grant is preceded by exactly one idle cycle.
    drain(1000, cyc);
    checkOutput("scenA_cycles", cyc, 2 * 2 * GL * 8 + 4);
    repeat (2) stepCycle();

    // B: only S1 active while downstream ready toggles every cycle.
    ready_toggle  = 1'b1;
    M_AXIS_TREADY = 1'b0;
    for (int l = 0; l < 2 * GL; l++) makeLine(1, l, 5, -1, 1'b0);
    applyStimulus();
    drain(1000, cyc);
    repeat (2) stepCycle();
    ready_toggle  = 1'b0;
    M_AXIS_TREADY = 1'b1;

    // C: a stray TUSER on beat 3 of line 2 sets the sticky error. Reset in the
    // middle of line 3 then truncates the packet.
    for (int l = 0; l < 3; l++) makeLine(0, l, 6, (l == 2) ? 3 : -1, 1'b0);
    applyStimulus();
    drain(1000, cyc);
    makeLine(0, 3, 6, -1, 1'b0);
    applyStimulus();
    repeat (4) stepCycle();
    checkOutput("sof_err_sticky", SOF_ERR, 1);
    checkOutput("midline_owner", GRANT, 2'b01);
    resetn = 1'b0;
    #1 checkOutput("reset_gates_now", {GRANT, M_AXIS_TVALID, S0_AXIS_TREADY}, '0);
    @(posedge clk);
    #1;
    checkOutput("reset_no_frame_done", FRAME_DONE, 0);
    checkOutput("reset_clears", {SOF_ERR, LINE_CNT}, '0);
    s0_q.delete();
    s1_q.delete();
    exp_q.delete();
    applyStimulus();
    resetModel();
    @(posedge clk);
    #1 resetn = 1'b1;
    first_after_reset = 1'b1;

    // D: S1 offers a frame whose first beat has TUSER=0.
    for (int l = 0; l < GL; l++) makeLine(1, l, 3, -1, (l == 0));
    applyStimulus();
`ifdef ARB_FRAME_LOCK_EN
    repeat (4) begin
      stepCycle();
      checkOutput("no_grant_without_sof", {GRANT, S1_AXIS_TREADY}, '0);
    end
    s1_q[0].user      = 1'b1;
    exp_q[0].beat.user = 1'b1;
    applyStimulus();
`else
    checkOutput("idle_before_grant", GRANT, 2'b00);
    stepCycle();
    checkOutput("grant_ignores_tuser", GRANT, 2'b10);
`endif
    drain(1000, cyc);
    repeat (2) stepCycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
